// File: rtl/serial_mem_server_if.sv
// -----------------------------------------------------------------------------
// serial_mem_server_if
// Narrow byte-serial bus between the CPU core (master) and the memory
// server (slave).
//   bus_pc            : CPU requests an instruction fetch
//   bus_mar           : CPU requests a data access
//   bus_mdr           : with bus_mar, 1 = store, 0 = load
//   halt              : CPU halted; server ignores new requests
//   out_bus           : CPU-to-server bytes (address, store data)
//   in_bus            : server-to-CPU bytes
//   ard_data_ready    : in_bus holds a valid byte this cycle
//   ard_receive_ready : server idle and accepting a request
// -----------------------------------------------------------------------------
interface serial_mem_server_if #(
   parameter int BUS_W = 8
);
   logic             bus_pc;
   logic             bus_mar;
   logic             bus_mdr;
   logic             halt;
   logic [BUS_W-1:0] out_bus;
   logic [BUS_W-1:0] in_bus;
   logic             ard_data_ready;
   logic             ard_receive_ready;

   modport master (
      output bus_pc, bus_mar, bus_mdr, halt, out_bus,
      input  in_bus, ard_data_ready, ard_receive_ready
   );

   modport slave (
      input  bus_pc, bus_mar, bus_mdr, halt, out_bus,
      output in_bus, ard_data_ready, ard_receive_ready
   );
endinterface

// File: rtl/serial_mem_server.sv
// -----------------------------------------------------------------------------
// serial_mem_server
// Serves instruction fetches and data loads/stores for the CPU core over a
// byte-serial bus, from internal instruction and data memories.
//
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   sbus         : serial_mem_server_if.slave (request/handshake/byte bus)
//   prog_we/addr/data : host write port into instruction memory
//   dbg_addr/dbg_data : combinational data-memory debug read
//   fetch_count  : completed fetches, saturating at 16'hFFFF
//   addr_err     : (SERIAL_MEM_ADDR_CHK_EN only) one-cycle pulse when a
//                  completed address is outside the targeted memory
//
// Build option: define SERIAL_MEM_ADDR_CHK_EN to add out-of-range address
// checking; otherwise addresses wrap modulo the memory depth.
// -----------------------------------------------------------------------------
module serial_mem_server #(
   parameter int          DATA_W        = 16,
   parameter int          BUS_W         = 8,
   parameter int          IMEM_DEPTH    = 16,
   parameter int          DMEM_DEPTH    = 16,
   parameter logic [15:0] EXT_TYPE_MASK = 16'h0006
) (
   input  logic                          clk,
   input  logic                          rst,
   serial_mem_server_if.slave            sbus,
   input  logic                          prog_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
   input  logic [DATA_W-1:0]             prog_data,
   input  logic [$clog2(DMEM_DEPTH)-1:0] dbg_addr,
   output logic [DATA_W-1:0]             dbg_data,
   output logic [15:0]                   fetch_count
`ifdef SERIAL_MEM_ADDR_CHK_EN
   ,output logic                         addr_err
`endif
);
   localparam int NB  = DATA_W / BUS_W;
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);
   localparam int CW  = $clog2(2*NB + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_SEND  = 3'd2;
   localparam logic [2:0] S_RECV  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;

   localparam logic [1:0] K_FETCH = 2'd0;
   localparam logic [1:0] K_LOAD  = 2'd1;
   localparam logic [1:0] K_STORE = 2'd2;

   logic [DATA_W-1:0]   r_imem [IMEM_DEPTH];
   logic [DATA_W-1:0]   r_dmem [DMEM_DEPTH];

   logic [2:0]          r_state;
   logic [1:0]          r_kind;
   logic [CW-1:0]       r_cnt;
   logic [CW-1:0]       r_total;
   logic [DATA_W-1:0]   r_addr;
   logic [2*DATA_W-1:0] r_shift;
   logic [DATA_W-1:0]   r_data;
   logic [BUS_W-1:0]    r_in_bus;
   logic                r_dv;
   logic                r_rdy;
   logic [15:0]         r_fcnt;
   logic                r_drop;
`ifdef SERIAL_MEM_ADDR_CHK_EN
   logic                r_err;
`endif

   logic                w_accept;
   logic [1:0]          w_req_kind;
   logic [1:0]          w_kind;
   logic [DATA_W-1:0]   w_addr_full;
   logic                w_addr_done;
   logic [IAW-1:0]      w_iidx;
   logic [IAW-1:0]      w_iidx_nx;
   logic [DAW-1:0]      w_didx;
   logic [DATA_W-1:0]   w_word;
   logic [DATA_W-1:0]   w_word_eff;
   logic [DATA_W-1:0]   w_ext_word;
   logic                w_ext;
   logic                w_ext_eff;
   logic                w_oor;
   logic [DATA_W-1:0]   w_data_nx;

   // Request acceptance: only when idle, advertising ready and not halted.
   // Fetch wins over data access.
   assign w_accept   = (r_state == S_IDLE) && r_rdy && !sbus.halt &&
                       (sbus.bus_pc || sbus.bus_mar);
   assign w_req_kind = sbus.bus_pc  ? K_FETCH :
                       sbus.bus_mdr ? K_STORE : K_LOAD;
   assign w_kind     = (r_state == S_IDLE) ? w_req_kind : r_kind;

   // Address assembled LSB first; the byte on out_bus this cycle is merged in
   // so the memory lookup can happen on the cycle the last byte arrives.
   always_comb begin
      w_addr_full = r_addr;
      if (r_state == S_IDLE)
         w_addr_full = DATA_W'(sbus.out_bus);
      else
         w_addr_full = r_addr | (DATA_W'(sbus.out_bus) << (BUS_W * r_cnt));
   end

   assign w_addr_done = (w_accept && (NB == 1)) ||
                        ((r_state == S_ADDR) && (r_cnt == CW'(NB - 1)));

   assign w_iidx     = w_addr_full[IAW-1:0];
   assign w_iidx_nx  = w_iidx + 1'b1;
   assign w_didx     = w_addr_full[DAW-1:0];
   assign w_word     = (w_kind == K_FETCH) ? r_imem[w_iidx] : r_dmem[w_didx];
   // Both words are latched together so a host write during SEND cannot
   // change what is already on its way out.
   assign w_ext_word = r_imem[w_iidx_nx];
   assign w_ext      = (w_kind == K_FETCH) && EXT_TYPE_MASK[w_word[3:0]];

`ifdef SERIAL_MEM_ADDR_CHK_EN
   localparam logic [DATA_W:0] IDEPTH_L = (DATA_W+1)'(IMEM_DEPTH);
   localparam logic [DATA_W:0] DDEPTH_L = (DATA_W+1)'(DMEM_DEPTH);
   assign w_oor = (w_kind == K_FETCH) ? ({1'b0, w_addr_full} >= IDEPTH_L)
                                      : ({1'b0, w_addr_full} >= DDEPTH_L);
`else
   assign w_oor = 1'b0;
`endif

   assign w_word_eff = w_oor ? '0 : w_word;
   assign w_ext_eff  = w_ext && !w_oor;
   assign w_data_nx  = (r_data >> BUS_W) |
                       (DATA_W'(sbus.out_bus) << (DATA_W - BUS_W));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_in_bus <= '0;
         r_dv     <= 1'b0;
         r_rdy    <= 1'b0;
         r_fcnt   <= '0;
         r_drop   <= 1'b0;
`ifdef SERIAL_MEM_ADDR_CHK_EN
         r_err    <= 1'b0;
`endif
      end else begin
`ifdef SERIAL_MEM_ADDR_CHK_EN
         r_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               r_rdy <= !sbus.halt;
               if (w_accept) begin
                  r_kind  <= w_req_kind;
                  r_addr  <= w_addr_full;
                  r_cnt   <= CW'(1);
                  r_rdy   <= 1'b0;
                  r_state <= S_ADDR;
               end
            end
            S_ADDR: begin
               r_addr <= w_addr_full;
               r_cnt  <= r_cnt + 1'b1;
            end
            S_SEND: begin
               // r_cnt counts bytes already presented on in_bus
               if (r_cnt == r_total) begin
                  r_dv    <= 1'b0;
                  r_rdy   <= !sbus.halt;
                  r_state <= S_IDLE;
                  if (r_kind == K_FETCH && r_fcnt != 16'hFFFF)
                     r_fcnt <= r_fcnt + 1'b1;
               end else begin
                  r_in_bus <= r_shift[BUS_W-1:0];
                  r_shift  <= r_shift >> BUS_W;
                  r_cnt    <= r_cnt + 1'b1;
               end
            end
            S_RECV: begin
               r_data <= w_data_nx;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == CW'(NB - 1))
                  r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_rdy   <= !sbus.halt;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         // Address complete: latch the word(s) and present the first byte on
         // the very next cycle, or switch to receiving store data.
         if (w_addr_done) begin
            r_addr <= w_addr_full;
            r_drop <= w_oor;
`ifdef SERIAL_MEM_ADDR_CHK_EN
            r_err  <= w_oor;
`endif
            r_rdy  <= 1'b0;
            if (w_kind == K_STORE) begin
               r_cnt   <= '0;
               r_state <= S_RECV;
            end else begin
               r_in_bus <= w_word_eff[BUS_W-1:0];
               r_shift  <= {w_ext_word, w_word_eff} >> BUS_W;
               r_total  <= w_ext_eff ? CW'(2*NB) : CW'(NB);
               r_cnt    <= CW'(1);
               r_dv     <= 1'b1;
               r_state  <= S_SEND;
            end
         end
      end
   end

   // Gated by rst so a reset landing on the WRITE cycle aborts the store.
   always_ff @(posedge clk) begin
      if (rst && (r_state == S_WRITE) && !r_drop)
         r_dmem[r_addr[DAW-1:0]] <= r_data;
   end

   always_ff @(posedge clk) begin
      if (prog_we)
         r_imem[prog_addr] <= prog_data;
   end

   assign dbg_data               = r_dmem[dbg_addr];
   assign fetch_count            = r_fcnt;
   assign sbus.in_bus            = r_in_bus;
   assign sbus.ard_data_ready    = r_dv;
   assign sbus.ard_receive_ready = r_rdy;
`ifdef SERIAL_MEM_ADDR_CHK_EN
   assign addr_err               = r_err;
`endif

endmodule

// File: tb/tb_serial_mem_server.sv
// -----------------------------------------------------------------------------
// tb_serial_mem_server
// Scoreboard bench: stimulus tasks push expected in_bus bytes computed from a
// word-level memory model; a negedge monitor pops and compares every byte the
// server presents with ard_data_ready.
// -----------------------------------------------------------------------------
module tb_serial_mem_server;
   localparam logic [15:0] EXT_MASK = 16'h0006;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   serial_mem_server_if #(.BUS_W(8)) bif ();

   logic        prog_we   = 1'b0;
   logic [3:0]  prog_addr = '0;
   logic [15:0] prog_data = '0;
   logic [3:0]  dbg_addr  = '0;
   logic [15:0] dbg_data;
   logic [15:0] fetch_count;
`ifdef SERIAL_MEM_ADDR_CHK_EN
   logic        addr_err;
`endif

   serial_mem_server dut (
      .clk         (clk),
      .rst         (rst),
      .sbus        (bif.slave),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data),
      .fetch_count (fetch_count)
`ifdef SERIAL_MEM_ADDR_CHK_EN
      ,.addr_err   (addr_err)
`endif
   );

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  exp_q [$];
   logic [15:0] m_imem [16];
   logic [15:0] m_dmem [16];
   int          m_fcnt   = 0;
   int          err_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every byte shown with ard_data_ready must match the queue head.
   always @(negedge clk) begin
      if (bif.ard_data_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got %h expected none", bif.in_bus);
         end else begin
            chk("in_bus", bif.in_bus, exp_q.pop_front());
         end
      end
`ifdef SERIAL_MEM_ADDR_CHK_EN
      if (addr_err === 1'b1) err_seen++;
`endif
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(input string name);
      int n = 0;
      while (bif.ard_receive_ready !== 1'b1 && n < 40) begin
         cyc();
         n++;
      end
      if (n >= 40) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: ready=%b required 1", name, bif.ard_receive_ready);
      end
   endtask

   task automatic prog(input logic [3:0] a, input logic [15:0] d);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_data = d;
      cyc();
      prog_we   = 1'b0;
      m_imem[a] = d;
   endtask

   function automatic bit out_of_range(input logic [15:0] addr);
`ifdef SERIAL_MEM_ADDR_CHK_EN
      return addr >= 16'd16;
`else
      return 1'b0;
`endif
   endfunction

   task automatic push_word(input logic [15:0] w);
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
   endtask

   // kind: 0 fetch, 1 load, 2 store, 3 fetch with bus_mar/bus_mdr also set
   task automatic txn(input int kind, input logic [15:0] addr, input logic [15:0] data,
                      input bit prog_mid, input bit halt_mid);
      bit oor;
      int err0;
      int idx;
      logic [15:0] w;
      wait_rdy("pre_txn");
      err0 = err_seen;
      idx  = int'(addr) % 16;
      oor  = out_of_range(addr);
      if (kind != 2) begin
         if (oor) push_word(16'h0000);
         else begin
            w = (kind == 1) ? m_dmem[idx] : m_imem[idx];
            push_word(w);
            if (kind != 1 && ((EXT_MASK >> w[3:0]) & 16'd1) == 16'd1)
               push_word(m_imem[(idx + 1) % 16]);
         end
         if (kind != 1 && m_fcnt < 65535) m_fcnt++;
      end
      bif.bus_pc  = (kind == 0 || kind == 3);
      bif.bus_mar = (kind != 0);
      bif.bus_mdr = (kind == 2 || kind == 3);
      bif.out_bus = addr[7:0];
      cyc();
      bif.bus_pc  = 1'b0;
      bif.bus_mar = 1'b0;
      bif.bus_mdr = 1'b0;
      bif.out_bus = addr[15:8];
      bif.halt    = halt_mid;
      cyc();
      bif.halt    = 1'b0;
      if (kind == 2) begin
         bif.out_bus = data[7:0];
         cyc();
         bif.out_bus = data[15:8];
         cyc();
         if (!oor) m_dmem[idx] = data;
      end else if (prog_mid) begin
         prog(addr[3:0], ~m_imem[idx]);
      end
      wait_rdy("post_txn");
      chk("queue_drained", exp_q.size(), 0);
      chk("fetch_count", fetch_count, m_fcnt);
`ifdef SERIAL_MEM_ADDR_CHK_EN
      chk("addr_err_pulses", err_seen - err0, oor);
`endif
      if (kind == 2) begin
         dbg_addr = addr[3:0];
         #1;
         chk("dbg_data", dbg_data, m_dmem[idx]);
      end
   endtask

   initial begin
      logic [15:0] a;
      int op;
      bif.bus_pc  = 1'b0;
      bif.bus_mar = 1'b0;
      bif.bus_mdr = 1'b0;
      bif.halt    = 1'b0;
      bif.out_bus = '0;

      // Reset state
      repeat (3) cyc();
      chk("rst_in_bus", bif.in_bus, 0);
      chk("rst_data_ready", bif.ard_data_ready, 0);
      chk("rst_receive_ready", bif.ard_receive_ready, 0);
      chk("rst_fetch_count", fetch_count, 0);
      rst = 1'b1;
      cyc();
      chk("ready_after_release", bif.ard_receive_ready, 1);

      // Known memory contents
      for (int i = 0; i < 16; i++) prog(4'(i), 16'($urandom));
      for (int i = 0; i < 16; i++) txn(2, 16'(i), 16'($urandom), 0, 0);

      // Basic fetch
      prog(4'd3, 16'h1230);
      txn(0, 16'h0003, 16'h0, 0, 0);
      chk("basic_fetch_count", fetch_count, 1);

      // Extended fetch
      prog(4'd1, 16'hA011);
      prog(4'd2, 16'h0005);
      txn(0, 16'h0001, 16'h0, 0, 0);

      // Store then load
      txn(2, 16'h0004, 16'h000B, 0, 0);
      txn(1, 16'h0004, 16'h0, 0, 0);

      // Host write to the word being sent
      txn(0, 16'h0003, 16'h0, 1, 0);

      // Reset mid-store
      wait_rdy("pre_rst_store");
      bif.bus_mar = 1'b1;
      bif.bus_mdr = 1'b1;
      bif.out_bus = 8'h04;
      cyc();
      bif.bus_mar = 1'b0;
      bif.bus_mdr = 1'b0;
      bif.out_bus = 8'h00;
      cyc();
      bif.out_bus = 8'h34;
      cyc();
      rst = 1'b0;
      cyc();
      m_fcnt = 0;
      chk("midrst_in_bus", bif.in_bus, 0);
      chk("midrst_data_ready", bif.ard_data_ready, 0);
      chk("midrst_receive_ready", bif.ard_receive_ready, 0);
      chk("midrst_fetch_count", fetch_count, 0);
      cyc();
      rst = 1'b1;
      cyc();
      chk("midrst_ready_release", bif.ard_receive_ready, 1);
      dbg_addr = 4'd4;
      #1;
      chk("midrst_dmem_kept", dbg_data, 16'h000B);

`ifdef SERIAL_MEM_ADDR_CHK_EN
      // Out-of-range accesses
      txn(1, 16'h0010, 16'h0, 0, 0);
      txn(2, 16'h0012, 16'hDEAD, 0, 0);
      dbg_addr = 4'd2;
      #1;
      chk("oor_store_dropped", dbg_data, m_dmem[2]);
`else
      // Wrap of extension word and of full address
      prog(4'd15, 16'h0001);
      prog(4'd0, 16'hBEEF);
      txn(0, 16'h000F, 16'h0, 0, 0);
      txn(0, 16'h0013, 16'h0, 0, 0);
`endif

      // Halt blocks requests
      bif.halt    = 1'b1;
      bif.bus_mar = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("halt_receive_ready", bif.ard_receive_ready, 0);
         chk("halt_data_ready", bif.ard_data_ready, 0);
      end
      bif.halt    = 1'b0;
      bif.bus_mar = 1'b0;
      cyc();
      chk("unhalt_receive_ready", bif.ard_receive_ready, 1);

      // Fetch priority over data access
      txn(3, 16'h0001, 16'h0, 0, 0);

      // Randomized mix
      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 3));
         a  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
         if (op == 3) prog(a[3:0], 16'($urandom));
         else txn(op, a, 16'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0));
      end

      repeat (2) cyc();
      chk("final_queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: sim time %0t required completion", $time);
      $fatal(1, "timeout");
   end
endmodule
